// File: rtl/tri_load_pkg.sv
// Shared types and constants for the triangle memory loader.
//   state_t    : frame parser states.
//   err_code_t : abort reason reported on err_code_out.
//   TRI_BYTES  : payload bytes per triangle (three 32-bit vertices).
//   TRI_W      : width of one packed triangle word.
package tri_load_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CNT_HI,
    CNT_LO,
    PAYLOAD,
    CHECK
  } state_t;

  typedef enum logic [1:0] {
    ERR_NONE,
    ERR_CKSUM,
    ERR_TIMEOUT,
    ERR_COUNT
  } err_code_t;

  localparam int TRI_BYTES = 12;
  localparam int TRI_W     = 96;

endpackage

// File: rtl/tri_word_packer.sv
// Packs a little-endian byte stream into 96-bit triangle words.
// Bytes shift in at the top of the word, so after TRI_BYTES bytes the first
// byte sits in bits [7:0] (v0 byte 0) and the last in bits [95:88].
//   clk_in         : system clock.
//   rst_in         : asynchronous active-low reset.
//   clear_in       : drop any partial word and restart at byte 0.
//   byte_valid_in  : byte_in is a payload byte to pack this cycle.
//   byte_in        : payload byte.
//   word_ready_out : this cycle's byte completes a word (combinational).
//   word_out       : the word including this cycle's byte; complete when
//                    word_ready_out is high.
module tri_word_packer
  import tri_load_pkg::*;
(
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             clear_in,
  input  logic             byte_valid_in,
  input  logic [7:0]       byte_in,
  output logic             word_ready_out,
  output logic [TRI_W-1:0] word_out
);

  logic [3:0]       byte_cnt_q;
  logic [TRI_W-1:0] shift_q;

  // The completed word is offered in the same cycle as its last byte so the
  // parent can register it without an extra cycle of latency.
  assign word_out       = {byte_in, shift_q[TRI_W-1:8]};
  assign word_ready_out = byte_valid_in && (byte_cnt_q == 4'(TRI_BYTES - 1));

  // NOTE: state is updated with non-blocking assignments so every register
  // samples the values from before the clock edge, independent of order.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      byte_cnt_q <= '0;
      shift_q    <= '0;
    end else if (clear_in) begin
      byte_cnt_q <= '0;
    end else if (byte_valid_in) begin
      shift_q    <= word_out;
      byte_cnt_q <= word_ready_out ? 4'd0 : byte_cnt_q + 4'd1;
    end
  end

endmodule

// File: rtl/tri_mem_loader.sv
// Writer side of the triangle memory read by the vertex shader.
// Parses frames  SYNC, count_hi, count_lo, N*12 payload bytes, checksum
// from a byte link, writes one {v2, v1, v0} word per triangle to sequential
// addresses from 0 and publishes the committed triangle count.
//   clk_in        : system clock.
//   rst_in        : asynchronous active-low reset.
//   byte_in       : received byte.
//   byte_valid_in : byte_in valid this cycle (no backpressure).
//   wr_en_out     : RAM write enable.
//   wr_addr_out   : RAM write address (triangle index).
//   wr_data_out   : RAM write data {v2, v1, v0}.
//   tri_count_out : committed triangle count.
//   load_done_out : one-cycle pulse, frame committed.
//   error_out     : one-cycle pulse, frame aborted.
//   err_code_out  : abort reason, held until the next accepted SYNC.
//   busy_out      : parser is inside a frame.
module tri_mem_loader
  import tri_load_pkg::*;
#(
  parameter int         ADDR_W         = 16,
  parameter logic [7:0] SYNC_BYTE      = 8'hA5,
  parameter int         MAX_TRIS       = 65535,
  parameter int         TIMEOUT_CYCLES = 1_000_000
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic [7:0]        byte_in,
  input  logic              byte_valid_in,
  output logic              wr_en_out,
  output logic [ADDR_W-1:0] wr_addr_out,
  output logic [TRI_W-1:0]  wr_data_out,
  output logic [15:0]       tri_count_out,
  output logic              load_done_out,
  output logic              error_out,
  output logic [1:0]        err_code_out,
  output logic              busy_out
);

  localparam int TMR_W = $clog2(TIMEOUT_CYCLES + 1);

  state_t            state_q, state_d;
  logic [7:0]        cnt_hi_q;
  logic [15:0]       n_q;
  logic [ADDR_W-1:0] tri_idx_q;
  logic [7:0]        cksum_q;
  logic [TMR_W-1:0]  timer_q;
  err_code_t         err_code_q;

  logic              timeout_hit;
  logic              byte_acc;
  logic [15:0]       count_n;
  logic              count_bad;
  logic              last_tri;
  logic              pk_valid;
  logic              pk_clear;
  logic              word_ready;
  logic [TRI_W-1:0]  word;

  // Output-process strobes.
  logic              sync_acc;
  logic              commit;
  logic              abort;
  err_code_t         abort_code;

  // On the timeout cycle the frame is abandoned and any byte present is lost.
  assign timeout_hit = (state_q != IDLE) && (timer_q == TMR_W'(TIMEOUT_CYCLES));
  assign byte_acc    = byte_valid_in && !timeout_hit;
  assign count_n     = {cnt_hi_q, byte_in};
  assign count_bad   = 32'(count_n) > MAX_TRIS;
  assign last_tri    = (32'(tri_idx_q) + 32'd1) == 32'(n_q);
  assign pk_valid    = byte_acc && (state_q == PAYLOAD);
  assign pk_clear    = sync_acc || abort;

  tri_word_packer u_packer (
    .clk_in        (clk_in),
    .rst_in        (rst_in),
    .clear_in      (pk_clear),
    .byte_valid_in (pk_valid),
    .byte_in       (byte_in),
    .word_ready_out(word_ready),
    .word_out      (word)
  );

  // State register.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) state_q <= IDLE;
    else         state_q <= state_d;
  end

  // Next-state logic.
  // NOTE: every signal assigned in a combinational block gets a default at
  // the top, so no path through the block can infer a latch.
  always_comb begin
    state_d = state_q;
    if (timeout_hit) begin
      state_d = IDLE;
    end else if (byte_valid_in) begin
      case (state_q)
        IDLE:    if (byte_in == SYNC_BYTE) state_d = CNT_HI;
        CNT_HI:  state_d = CNT_LO;
        CNT_LO: begin
          if (count_bad)          state_d = IDLE;
          else if (count_n == '0) state_d = CHECK;
          else                    state_d = PAYLOAD;
        end
        PAYLOAD: if (word_ready && last_tri) state_d = CHECK;
        CHECK:   state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  // Output logic: busy flag and the per-cycle frame events.
  always_comb begin
    busy_out   = (state_q != IDLE);
    sync_acc   = 1'b0;
    commit     = 1'b0;
    abort      = 1'b0;
    abort_code = ERR_NONE;
    if (timeout_hit) begin
      abort      = 1'b1;
      abort_code = ERR_TIMEOUT;
    end else if (byte_valid_in) begin
      case (state_q)
        IDLE:   sync_acc = (byte_in == SYNC_BYTE);
        CNT_LO: begin
          if (count_bad) begin
            abort      = 1'b1;
            abort_code = ERR_COUNT;
          end
        end
        CHECK: begin
          if (byte_in == cksum_q) begin
            commit = 1'b1;
          end else begin
            abort      = 1'b1;
            abort_code = ERR_CKSUM;
          end
        end
        default: ;
      endcase
    end
  end

  // Frame datapath and registered outputs.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      cnt_hi_q      <= '0;
      n_q           <= '0;
      tri_idx_q     <= '0;
      cksum_q       <= '0;
      timer_q       <= '0;
      err_code_q    <= ERR_NONE;
      wr_en_out     <= 1'b0;
      wr_addr_out   <= '0;
      wr_data_out   <= '0;
      tri_count_out <= '0;
      load_done_out <= 1'b0;
      error_out     <= 1'b0;
    end else begin
      wr_en_out     <= 1'b0;
      load_done_out <= 1'b0;
      error_out     <= 1'b0;

      if (sync_acc) begin
        err_code_q <= ERR_NONE;
        tri_idx_q  <= '0;
        cksum_q    <= '0;
      end
      if (abort) begin
        error_out  <= 1'b1;
        err_code_q <= abort_code;
      end
      if (commit) begin
        load_done_out <= 1'b1;
        tri_count_out <= n_q;
      end

      if (byte_acc && state_q == CNT_HI) cnt_hi_q <= byte_in;
      if (byte_acc && state_q == CNT_LO) n_q      <= count_n;
      if (pk_valid)                      cksum_q  <= cksum_q ^ byte_in;

      // Address and data only move on a write, so they hold otherwise.
      if (word_ready) begin
        wr_en_out   <= 1'b1;
        wr_addr_out <= tri_idx_q;
        wr_data_out <= word;
        tri_idx_q   <= tri_idx_q + 1'b1;
      end

      // Counts idle cycles inside a frame; any accepted byte restarts it.
      if (state_q == IDLE || timeout_hit || byte_valid_in) timer_q <= '0;
      else                                                 timer_q <= timer_q + TMR_W'(1);
    end
  end

  assign err_code_out = err_code_q;

endmodule

// File: doc/tri_mem_loader.md
Name: tri_mem_loader

Overview:
- Writer side of the triangle memory that the vertex shader reads: one 96-bit word per triangle, {v2, v1, v0}, 32 bits each, v0 in the LSBs.
- Receives a framed byte stream from the host byte link (UART receiver or similar), packs 12 bytes per triangle and writes them to sequential RAM addresses from 0.
- Publishes the committed triangle count, which the vertex shader uses as its read bound.

Parameters:
- ADDR_W, 16: RAM address width.
- SYNC_BYTE, 8'hA5: frame start marker.
- MAX_TRIS, 65535: largest accepted triangle count; must not exceed 2^ADDR_W.
- TIMEOUT_CYCLES, 1_000_000: idle cycles allowed between bytes inside a frame.

Ports:
- clk_in  input  1  system clock.
- rst_in  input  1  reset; asynchronous, active-low.
- byte_in  input  8  received byte.
- byte_valid_in  input  1  byte_in valid this cycle; no backpressure.
- wr_en_out  output  1  RAM write enable.
- wr_addr_out  output  ADDR_W  RAM write address.
- wr_data_out  output  96  RAM write data, {v2, v1, v0}.
- tri_count_out  output  16  committed triangle count.
- load_done_out  output  1  one-cycle pulse: frame committed.
- error_out  output  1  one-cycle pulse: frame aborted.
- err_code_out  output  2  0 none, 1 checksum, 2 timeout, 3 count too large.
- busy_out  output  1  high in any state other than IDLE.

Behaviour:
- Reset (asynchronous assert, any time, including mid-frame):
  - State goes to IDLE.
  - All outputs go to 0, including tri_count_out and err_code_out.
  - Byte, triangle, checksum and timeout counters clear.
- Frame format:
  - SYNC_BYTE, then count_hi, then count_lo, giving N.
  - Then N×12 payload bytes. Per triangle: v0 bytes 0-3 little-endian, then v1, then v2.
  - Then one checksum byte, equal to the XOR of all payload bytes (0x00 when N=0).
- State machine:
  - IDLE: a byte equal to SYNC_BYTE goes to CNT_HI and clears err_code_out; any other byte is ignored.
  - CNT_HI: latch the high count byte, go to CNT_LO.
  - CNT_LO: form N. N > MAX_TRIS aborts with code 3 and returns to IDLE. N = 0 goes to CHECK. Otherwise go to PAYLOAD.
  - PAYLOAD: pack the byte and XOR it into the checksum. When the 12th byte of a triangle is accepted, the write fires on the next cycle: wr_en_out=1, wr_addr_out = triangle index, wr_data_out = packed word. After triangle N-1, go to CHECK.
  - CHECK: if the byte equals the checksum, tri_count_out <= N and load_done_out pulses on the next cycle. If it does not match, the frame aborts with code 1 and tri_count_out is unchanged. Either way, return to IDLE.
- Abort: error_out pulses 1 cycle; err_code_out holds its value until the next SYNC_BYTE is accepted in IDLE.
- Write timing: writes are not retracted on abort, so RAM contents past the committed count are undefined. wr_addr_out and wr_data_out hold their last values when wr_en_out=0.
- Timeout counter:
  - Runs only outside IDLE and clears on every accepted byte.
  - Reaching TIMEOUT_CYCLES aborts with code 2 and returns to IDLE. A byte arriving on that same cycle is dropped.
- In-frame bytes: a byte equal to SYNC_BYTE inside a frame is treated as data, with no resync.
- Widths: the triangle index is ADDR_W bits; the in-triangle byte counter is 4 bits, 0..11; the checksum is 8 bits.

Decomposition:
- Package tri_load_pkg:
  - state enum {IDLE, CNT_HI, CNT_LO, PAYLOAD, CHECK}.
  - err_code enum {ERR_NONE, ERR_CKSUM, ERR_TIMEOUT, ERR_COUNT}.
  - TRI_BYTES=12, TRI_W=96.
- Sub-module tri_word_packer:
  - Byte-to-96-bit little-endian shift/pack with a byte counter.
  - Outputs a word_ready pulse.
  - Has a clear input driven from SYNC and abort.

Test Plan (bench overrides TIMEOUT_CYCLES=100, MAX_TRIS=4 where noted):
- Reset values: assert rst_in=0 mid-run -> all outputs 0 the same cycle, busy_out=0; release, then a non-sync byte 0x11 -> no state change.
- Good 2-triangle load: A5 00 02, payload bytes 0x01..0x18, checksum 0x18 (XOR of 0x01..0x18) -> exactly two writes:
  - addr 0, data {0C0B0A09, 08070605, 04030201}.
  - addr 1, data {18171615, 14131211, 100F0E0D}.
  - Then load_done_out pulse, tri_count_out=2.
- Bad checksum: same frame with checksum 0x00 -> two writes, error_out pulse, err_code_out=1, tri_count_out stays 2; next A5 clears err_code_out to 0.
- Timeout: A5 00 01, five payload bytes, then 100 idle cycles -> error_out pulse, err_code_out=2, busy_out=0; a following full valid frame loads normally.
- Count bounds:
  - A5 00 00 00 -> load_done_out pulse, tri_count_out=0, no writes.
  - With MAX_TRIS=4, A5 00 05 -> err_code_out=3 right after count_lo, no writes.
- Reset mid-payload: assert reset after byte 7 of triangle 0 -> no write occurs; a subsequent 1-triangle frame writes addr 0 with fresh data.
